// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised up/down counter with wrap or saturate behaviour,
//               synchronous clamped load and a registered terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             direction,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam bit               c_sat  = (SAT_MODE != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (r_count == c_max);
    assign w_at_min = (r_count == c_zero);

    always_comb begin
        w_next_count = r_count;
        w_next_tc    = 1'b0;
        if (load) begin
            // Out-of-range load values are clamped so the count stays legal.
            w_next_count = (load_val > c_max) ? c_max : load_val;
        end else if (enable) begin
            if (direction) begin
                if (w_at_max) begin
                    w_next_count = c_sat ? c_max : c_zero;
                    w_next_tc    = 1'b1;
                end else begin
                    w_next_count = r_count + 1'b1;
                end
            end else begin
                if (w_at_min) begin
                    w_next_count = c_sat ? c_zero : c_max;
                    w_next_tc    = 1'b1;
                end else begin
                    w_next_count = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_next_tc;
        end
    end

    assign counter_out = r_count;
    assign tc          = r_tc;
    assign at_max      = w_at_max;
    assign at_min      = w_at_min;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_param
// Description : Self-checking bench for updown_counter_param (wrap and
//               saturate instances, WIDTH=4, MAX_VAL=9).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_param;

    localparam int c_w = 4;
    localparam int c_m = 9;

    logic           clk;
    logic           rst;
    logic           enable;
    logic           direction;
    logic           load;
    logic [c_w-1:0] load_val;

    logic [c_w-1:0] out_w, out_s;
    logic           tc_w, tc_s, max_w, max_s, min_w, min_s;

    int checks;
    int errors;

    // Reference state, kept as plain integers.
    int model_w, model_s;
    bit mtc_w, mtc_s;

    updown_counter_param #(.WIDTH(c_w), .MAX_VAL(c_m), .SAT_MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .direction(direction),
        .load(load), .load_val(load_val), .counter_out(out_w), .tc(tc_w),
        .at_max(max_w), .at_min(min_w)
    );

    updown_counter_param #(.WIDTH(c_w), .MAX_VAL(c_m), .SAT_MODE(1)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .direction(direction),
        .load(load), .load_val(load_val), .counter_out(out_s), .tc(tc_s),
        .at_max(max_s), .at_min(min_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int next_count(int cur, bit sat, bit ld, int lv, bit en, bit dir);
        if (ld)            return (lv > c_m) ? c_m : lv;
        if (!en)           return cur;
        if (dir)           return (cur < c_m) ? cur + 1 : (sat ? c_m : 0);
        return (cur > 0) ? cur - 1 : (sat ? 0 : c_m);
    endfunction

    function automatic bit next_tc(int cur, bit ld, bit en, bit dir);
        return !ld && en && ((dir && cur == c_m) || (!dir && cur == 0));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_w <= 0;
            model_s <= 0;
            mtc_w   <= 1'b0;
            mtc_s   <= 1'b0;
        end else begin
            model_w <= next_count(model_w, 1'b0, load, int'(load_val), enable, direction);
            model_s <= next_count(model_s, 1'b1, load, int'(load_val), enable, direction);
            mtc_w   <= next_tc(model_w, load, enable, direction);
            mtc_s   <= next_tc(model_s, load, enable, direction);
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cmp("wrap_count",  int'(out_w), model_w);
        cmp("wrap_tc",     int'(tc_w),  int'(mtc_w));
        cmp("wrap_at_max", int'(max_w), int'(model_w == c_m));
        cmp("wrap_at_min", int'(min_w), int'(model_w == 0));
        cmp("sat_count",   int'(out_s), model_s);
        cmp("sat_tc",      int'(tc_s),  int'(mtc_s));
        cmp("sat_at_max",  int'(max_s), int'(model_s == c_m));
        cmp("sat_at_min",  int'(min_s), int'(model_s == 0));
    end

    // Apply inputs at the falling edge, let one rising edge pass, settle.
    task automatic step(input bit en, input bit dir, input bit ld, input int lv);
        @(negedge clk);
        enable    = en;
        direction = dir;
        load      = ld;
        load_val  = c_w'(lv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int up_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int dn_exp [4]  = '{1, 0, 9, 8};
        int sat_exp[5]  = '{8, 9, 9, 9, 9};
        int wr_exp [5]  = '{8, 9, 0, 1, 2};
        int tog_exp[4]  = '{6, 5, 6, 5};

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        direction = 1'b0;
        load      = 1'b0;
        load_val  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("rst_count", int'(out_w), 0);
        cmp("rst_tc",    int'(tc_w),  0);
        cmp("rst_min",   int'(min_w), 1);
        cmp("rst_max",   int'(max_w), 0);

        // Count up with wrap.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 0);
            cmp("up_wrap_count", int'(out_w), up_exp[i]);
            cmp("up_wrap_tc",    int'(tc_w),  int'(i == 9));
        end

        // Load 2 then count down through the wrap.
        step(1'b0, 1'b0, 1'b1, 2);
        cmp("dn_load", int'(out_w), 2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            cmp("dn_wrap_count", int'(out_w), dn_exp[i]);
            cmp("dn_wrap_tc",    int'(tc_w),  int'(i == 2));
        end

        // Saturate at the top, then step back down.
        step(1'b0, 1'b0, 1'b1, 7);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 0);
            cmp("sat_up_count", int'(out_s), sat_exp[i]);
            cmp("sat_up_tc",    int'(tc_s),  int'(i >= 2));
            cmp("sat_wrapinst", int'(out_w), wr_exp[i]);
        end
        step(1'b1, 1'b0, 1'b0, 0);
        cmp("sat_down_count", int'(out_s), 8);
        cmp("sat_down_tc",    int'(tc_s),  0);

        // Load beats enable and is clamped to MAX_VAL.
        step(1'b1, 1'b1, 1'b1, 13);
        cmp("clamp_count", int'(out_w), 9);
        cmp("clamp_tc",    int'(tc_w),  0);
        step(1'b1, 1'b1, 1'b0, 0);
        cmp("post_clamp_count", int'(out_w), 0);
        cmp("post_clamp_tc",    int'(tc_w),  1);

        // Hold, then direction toggling every cycle.
        step(1'b0, 1'b1, 1'b1, 5);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'(i), 1'b0, 0);
            cmp("hold_count", int'(out_w), 5);
            cmp("hold_tc",    int'(tc_w),  0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'((i + 1) % 2), 1'b0, 0);
            cmp("toggle_count", int'(out_w), tog_exp[i]);
        end

        // Asynchronous reset pulse between edges.
        step(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_rst_count", int'(out_w), 0);
        cmp("async_rst_scount", int'(out_s), 0);
        cmp("async_rst_min",   int'(min_w), 1);
        #1;
        rst = 1'b0;

        // Randomised traffic, checked every cycle by the compare process.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 199) == 0) begin
                #1;
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter, the successor to the fixed single-channel counter in the exercise set. Adds configurable width and modulus, wrap or saturate mode, synchronous parallel load, and a registered terminal-count pulse. Used as a generic event/step counter feeding display and timer logic at top level.

Parameters:
WIDTH, 8, counter bit width
MAX_VAL, 255, highest count value; legal range 1 .. 2^WIDTH-1; counter range is 0 .. MAX_VAL
SAT_MODE, 0, 0 = wrap at boundaries, 1 = saturate (hold) at boundaries

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
enable  input  1  count enable; one step per clock while high
direction  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load is high
counter_out  output  WIDTH  registered count value
tc  output  1  registered terminal-count pulse
at_max  output  1  high when counter_out == MAX_VAL (combinational from register)
at_min  output  1  high when counter_out == 0 (combinational from register)

Behaviour:
- Reset: rst high forces counter_out = 0 and tc = 0 immediately, regardless of clk; at_min = 1, at_max = 0 during reset. Registers hold these values until the first rising edge after rst deasserts.
- Priority per rising edge: rst > load > enable > hold.
- load high: counter_out <= min(load_val, MAX_VAL); tc <= 0; enable and direction are ignored that cycle.
- enable low, load low: counter_out holds; tc <= 0.
- enable high, direction 1:
  - counter_out < MAX_VAL: increment by 1, tc <= 0.
  - counter_out == MAX_VAL: SAT_MODE=0 -> counter_out <= 0, tc <= 1; SAT_MODE=1 -> hold at MAX_VAL, tc <= 1.
- enable high, direction 0:
  - counter_out > 0: decrement by 1, tc <= 0.
  - counter_out == 0: SAT_MODE=0 -> counter_out <= MAX_VAL, tc <= 1; SAT_MODE=1 -> hold at 0, tc <= 1.
- Latency: one clock. The new count and tc are visible after the edge at which enable, direction or load was sampled.
- tc width: tc is high for exactly one cycle per boundary event. In saturate mode with enable held at a boundary, tc stays high on every cycle, because a boundary event occurs every cycle.
- Direction change mid-count takes effect on the next edge with no dead cycle.
- Counter value is never outside 0..MAX_VAL; arithmetic is unsigned with no carry out beyond WIDTH.
- rst asserted mid-count aborts immediately; no pending tc survives reset.

Test Plan:
- Reset: rst=1 for 3 cycles, then release -> counter_out=0, tc=0, at_min=1, at_max=0; rst pulse between edges clears the count asynchronously.
- Count up wrap (WIDTH=4, MAX_VAL=9, SAT_MODE=0): enable=1, direction=1 for 12 cycles -> 0,1,..,9,0,1,2; tc=1 only in the cycle where counter_out shows 0 after 9.
- Count down wrap (same parameters): load_val=2 then enable=1, direction=0 -> 2,1,0,9,8; tc=1 only in the cycle showing 9.
- Saturate (MAX_VAL=9, SAT_MODE=1): count up from 7 for 5 cycles -> 8,9,9,9,9 with tc=1 on each hold cycle; then direction=0 -> 8, tc=0.
- Load priority and clamp: load=1, load_val=13 with enable=1, direction=1 (MAX_VAL=9) -> counter_out=9, tc=0; next cycle with load=0 -> 0, tc=1 (wrap mode).
- Hold and direction toggle: enable=0 for 4 cycles -> value unchanged; enable=1 with direction toggling every cycle from 5 -> 6,5,6,5.
